// File: rtl/id_ex_skid_reg_if.sv
// Valid/ready bundle channel carrying one decode-to-execute payload.
// master drives valid and payload, slave drives ready.
interface id_ex_skid_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] dr1;
  logic [DATA_W-1:0] dr2;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] imm;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid, dr1, dr2, rs, rt, rd, imm, ctrl,
    input  ready
  );

  modport slave (
    input  valid, dr1, dr2, rs, rt, rd, imm, ctrl,
    output ready
  );
endinterface

// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer,
// synchronous flush and a saturating back-pressure stall counter.
// Optional write-back operand bypass of held entries: ID_EX_WB_BYPASS_EN.
module id_ex_skid_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned STALL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  id_ex_skid_reg_if.slave    up,
  id_ex_skid_reg_if.master   dn,
  output logic [1:0]         o_occupancy,
  output logic [STALL_W-1:0] o_stall_cnt,
  input  logic               i_wb_we,
  input  logic [REG_AW-1:0]  i_wb_rd,
  input  logic [DATA_W-1:0]  i_wb_data
);

  typedef struct packed {
    logic [DATA_W-1:0] dr1;
    logic [DATA_W-1:0] dr2;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } bundle_t;

  // State bit 0 is M_v, bit 1 is S_v.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  bundle_t            r_m;
  bundle_t            r_s;
  bundle_t            w_m_nxt;
  bundle_t            w_s_nxt;
  bundle_t            w_in;
  bundle_t            w_in_cur;
  bundle_t            w_m_cur;
  bundle_t            w_s_cur;
  logic               r_in_ready;
  logic [1:0]         r_occ;
  logic [STALL_W-1:0] r_stall;
  logic               w_m_v;
  logic               w_accept;
  logic               w_retire;

  assign w_m_v    = r_state[0];
  assign w_accept = up.valid & r_in_ready;
  assign w_retire = w_m_v & dn.ready;

  assign w_in.dr1  = up.dr1;
  assign w_in.dr2  = up.dr2;
  assign w_in.rs   = up.rs;
  assign w_in.rt   = up.rt;
  assign w_in.rd   = up.rd;
  assign w_in.imm  = up.imm;
  assign w_in.ctrl = up.ctrl;

`ifdef ID_EX_WB_BYPASS_EN
  // Replace operands whose source index matches a live (non-r0) write-back.
  function automatic bundle_t f_bypass(input bundle_t b, input logic we,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [DATA_W-1:0] d);
    bundle_t o;
    o = b;
    if (we && (rd != '0)) begin
      if (b.rs == rd) o.dr1 = d;
      if (b.rt == rd) o.dr2 = d;
    end
    return o;
  endfunction

  assign w_m_cur  = f_bypass(r_m,  i_wb_we, i_wb_rd, i_wb_data);
  assign w_s_cur  = f_bypass(r_s,  i_wb_we, i_wb_rd, i_wb_data);
  assign w_in_cur = f_bypass(w_in, i_wb_we, i_wb_rd, i_wb_data);
`else
  logic w_unused_wb;

  assign w_unused_wb = ^{i_wb_we, i_wb_rd, i_wb_data};
  assign w_m_cur     = r_m;
  assign w_s_cur     = r_s;
  assign w_in_cur    = w_in;
`endif

  // Next-state and entry-load selection; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = w_m_cur;
    w_s_nxt     = w_s_cur;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_m_nxt     = w_in_cur;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && w_retire) begin
          w_m_nxt = w_in_cur;
        end else if (w_accept) begin
          w_s_nxt     = w_in_cur;
          w_state_nxt = ST_TWO;
        end else if (w_retire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_retire) begin
          w_m_nxt     = w_s_cur;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // State, entries and registered ready/occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_EMPTY;
      r_m        <= '0;
      r_s        <= '0;
      r_in_ready <= 1'b1;
      r_occ      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_m        <= w_m_nxt;
      r_s        <= w_s_nxt;
      r_in_ready <= ~w_state_nxt[1];
      r_occ      <= 2'({1'b0, w_state_nxt[0]}) + 2'({1'b0, w_state_nxt[1]});
    end
  end

  // Saturating count of cycles where execute holds off a valid head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall <= '0;
    end else if (w_m_v && !dn.ready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign up.ready    = r_in_ready;
  assign dn.valid    = w_m_v;
  assign dn.dr1      = r_m.dr1;
  assign dn.dr2      = r_m.dr2;
  assign dn.rs       = r_m.rs;
  assign dn.rt       = r_m.rt;
  assign dn.rd       = r_m.rd;
  assign dn.imm      = r_m.imm;
  assign dn.ctrl     = r_m.ctrl;
  assign o_occupancy = r_occ;
  assign o_stall_cnt = r_stall;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Scoreboard bench for id_ex_skid_reg: a queue model of the two held
// entries, popped and compared as execute consumes the head.
module tb_id_ex_skid_reg;

  typedef struct packed {
    logic [31:0] dr1;
    logic [31:0] dr2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  occ;
  logic [15:0] stall;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_stall = 0;
  bundle_t     q[$];
  bundle_t     drv;

  id_ex_skid_reg_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(8)) up_if ();
  id_ex_skid_reg_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(8)) dn_if ();

  id_ex_skid_reg #(.DATA_W(32), .REG_AW(5), .CTRL_W(8), .STALL_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .up          (up_if.slave),
    .dn          (dn_if.master),
    .o_occupancy (occ),
    .o_stall_cnt (stall),
    .i_wb_we     (wb_we),
    .i_wb_rd     (wb_rd),
    .i_wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t mk(input int unsigned n);
    bundle_t b;
    b.dr1  = 32'(n);
    b.dr2  = 32'h1000_0000 | 32'(n);
    b.rs   = 5'(n + 1);
    b.rt   = 5'(n + 2);
    b.rd   = 5'(n + 3);
    b.imm  = ~32'(n);
    b.ctrl = 8'(n * 7);
    return b;
  endfunction

  function automatic bundle_t get_out();
    bundle_t b;
    b.dr1  = dn_if.dr1;
    b.dr2  = dn_if.dr2;
    b.rs   = dn_if.rs;
    b.rt   = dn_if.rt;
    b.rd   = dn_if.rd;
    b.imm  = dn_if.imm;
    b.ctrl = dn_if.ctrl;
    return b;
  endfunction

  task automatic drive(input bundle_t b, input logic v);
    drv          = b;
    up_if.valid  = v;
    up_if.dr1    = b.dr1;
    up_if.dr2    = b.dr2;
    up_if.rs     = b.rs;
    up_if.rt     = b.rt;
    up_if.rd     = b.rd;
    up_if.imm    = b.imm;
    up_if.ctrl   = b.ctrl;
  endtask

  task automatic check_state();
    chk("out_valid", 128'(dn_if.valid), 128'(q.size() > 0));
    chk("in_ready",  128'(up_if.ready), 128'(q.size() < 2));
    chk("occupancy", 128'(occ),         128'(q.size()));
    chk("stall_cnt", 128'(stall),       128'(exp_stall));
    if (q.size() > 0) chk("head_bundle", 128'(get_out()), 128'(q[0]));
  endtask

  // One clock: update the model from the driven inputs, step, then check.
  task automatic tick();
    logic    m_valid;
    logic    m_ready;
    bundle_t t;
    m_valid = (q.size() > 0);
    m_ready = (q.size() < 2);
    if (m_valid && dn_if.ready) begin
      chk("retire_bundle", 128'(get_out()), 128'(q[0]));
      void'(q.pop_front());
    end
    if (flush) begin
      q.delete();
    end else if (up_if.valid && m_ready) begin
      q.push_back(drv);
    end
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_we && (wb_rd != 5'd0)) begin
      for (int i = 0; i < q.size(); i++) begin
        t = q[i];
        if (t.rs == wb_rd) t.dr1 = wb_data;
        if (t.rt == wb_rd) t.dr2 = wb_data;
        q[i] = t;
      end
    end
`endif
    if (m_valid && !dn_if.ready && (exp_stall != 32'hFFFF)) exp_stall++;
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
  endtask

  initial begin
    bundle_t b;
    rst_n       = 1'b0;
    flush       = 1'b0;
    wb_we       = 1'b0;
    wb_rd       = 5'd0;
    wb_data     = 32'd0;
    dn_if.ready = 1'b0;
    drive(mk(0), 1'b0);

    // Reset state
    @(negedge clk);
    check_state();
    chk("reset_dr1",  128'(dn_if.dr1),  128'(0));
    chk("reset_ctrl", 128'(dn_if.ctrl), 128'(0));
    rst_n = 1'b1;

    // Full-throughput streaming of 0x1, 0x2, 0x3
    dn_if.ready = 1'b1;
    drive(mk(1), 1'b1); tick();
    chk("stream_dr1_1", 128'(dn_if.dr1), 128'(32'h1));
    drive(mk(2), 1'b1); tick();
    chk("stream_dr1_2", 128'(dn_if.dr1), 128'(32'h2));
    drive(mk(3), 1'b1); tick();
    chk("stream_dr1_3", 128'(dn_if.dr1), 128'(32'h3));
    drive(mk(0), 1'b0); tick();

    // Back-pressure: fill both entries, offer a third while full, then drain
    dn_if.ready = 1'b0;
    drive(mk(32'hA), 1'b1); tick();
    drive(mk(32'hB), 1'b1); tick();
    chk("bp_head_a", 128'(dn_if.dr1), 128'(32'hA));
    drive(mk(32'hC), 1'b1); tick();
    drive(mk(0), 1'b0); tick();
    chk("bp_hold_a", 128'(dn_if.dr1), 128'(32'hA));
    dn_if.ready = 1'b1;
    tick();
    chk("bp_drain_b", 128'(dn_if.dr1), 128'(32'hB));
    tick();

    // Flush with two held entries and a same-cycle retire
    dn_if.ready = 1'b0;
    drive(mk(20), 1'b1); tick();
    drive(mk(21), 1'b1); tick();
    drive(mk(0), 1'b0);
    flush = 1'b1; dn_if.ready = 1'b1; tick();
    flush = 1'b0;

    // Flush discards a same-cycle accept
    dn_if.ready = 1'b0;
    drive(mk(22), 1'b1); tick();
    drive(mk(23), 1'b1); flush = 1'b1; tick();
    flush = 1'b0;
    drive(mk(0), 1'b0); tick();

    // Asynchronous reset mid-stream with two held entries
    drive(mk(30), 1'b1); tick();
    drive(mk(31), 1'b1); tick();
    drive(mk(0), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    exp_stall = 0;
    check_state();
    chk("async_rst_dr1", 128'(dn_if.dr1), 128'(0));
    #1 rst_n = 1'b1;
    tick();

    // Write-back bypass of a held entry
    b = mk(40); b.rs = 5'd5; b.dr1 = 32'h10; b.rt = 5'd6; b.dr2 = 32'h20;
    drive(b, 1'b1); tick();
    drive(mk(0), 1'b0);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD; tick();
`ifdef ID_EX_WB_BYPASS_EN
    chk("byp_rs_dr1", 128'(dn_if.dr1), 128'(32'hDEAD));
`else
    chk("byp_rs_dr1", 128'(dn_if.dr1), 128'(32'h10));
`endif
    wb_rd = 5'd0; wb_data = 32'hBEEF; tick();
`ifdef ID_EX_WB_BYPASS_EN
    chk("byp_r0_dr1", 128'(dn_if.dr1), 128'(32'hDEAD));
`else
    chk("byp_r0_dr1", 128'(dn_if.dr1), 128'(32'h10));
`endif
    wb_rd = 5'd6; wb_data = 32'h55; tick();
    wb_we = 1'b0; dn_if.ready = 1'b1; tick();

    // Bypass of a bundle loaded in the same cycle
    b = mk(50); b.rs = 5'd7; b.dr1 = 32'h70; b.rt = 5'd7; b.dr2 = 32'h71;
    drive(b, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h77; dn_if.ready = 1'b0; tick();
    wb_we = 1'b0; drive(mk(0), 1'b0); dn_if.ready = 1'b1; tick();
    chk("final_empty", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Decode-to-execute pipeline boundary with valid/ready handshake and a 2-entry skid buffer.
- Captures the decode stage's register-file read data (Dr1/Dr2), register indices, immediate and control word, and presents them to the execute stage.
- Provides back-pressure, synchronous flush for branch/jump squash, and a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, operand and immediate width.
- REG_AW, 5, register index width.
- CTRL_W, 8, packed control word width (ALUOp, MemRd, MemWr, RegWr, ALUSrc, etc.).
- STALL_W, 16, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous squash of all held entries.
- InValid  in  1  decode presents a valid bundle.
- InReady  out  1  block can accept a bundle this cycle.
- InDr1, InDr2  in  DATA_W  register-file read data.
- InRS, InRT, InRD  in  REG_AW  register indices.
- InImm  in  DATA_W  sign-extended immediate.
- InCtrl  in  CTRL_W  control word.
- OutValid  out  1  head bundle valid toward execute.
- OutReady  in  1  execute consumes head this cycle.
- OutDr1, OutDr2, OutRS, OutRT, OutRD, OutImm, OutCtrl  out  as inputs  head bundle.
- Occupancy  out  2  number of held entries (0..2).
- StallCnt  out  STALL_W  saturating count of cycles with OutValid=1 and OutReady=0.
- WbWE  in  1  write-back write enable (used only with the optional feature).
- WbRD  in  REG_AW  write-back destination.
- WbData  in  DATA_W  write-back data.

Behaviour:
- Storage: main entry M drives the Out* ports; skid entry S is used only when M is blocked.
- Valid bits are M_v and S_v.
- Accept = InValid & InReady. Retire = OutValid & OutReady.
- InReady is registered and equals !S_v. Its reset value is 1.
- OutValid = M_v.
- Occupancy = M_v + S_v.
- States:
  - EMPTY (M_v=0): on Accept, load M → ONE.
  - ONE (M_v=1, S_v=0):
    - Accept & Retire: load M with the new bundle, stay in ONE.
    - Accept & !Retire: load S → TWO.
    - Retire only → EMPTY.
  - TWO (M_v=1, S_v=1): InReady=0, so no Accept is possible. On Retire, M ← S and S_v=0 → ONE.
- Latency: a bundle accepted at edge N is visible on Out* with OutValid=1 after edge N; zero bubbles at full throughput.
- Ordering is strictly FIFO. No bundle is dropped or duplicated except by Flush.
- Flush has highest priority:
  - At the edge, M_v=0 and S_v=0, and InReady=1 afterwards.
  - A same-cycle Accept is discarded.
  - A same-cycle Retire still counts as consumed by execute.
  - Data registers are don't-care after Flush.
- Reset (async, RST_N=0):
  - M_v=0, S_v=0, InReady=1, StallCnt=0.
  - All Out* data outputs are 0; Occupancy=0.
  - Reset mid-transfer discards everything.
- StallCnt:
  - Increments on each edge where OutValid & !OutReady.
  - Saturates at all-ones.
  - Not cleared by Flush; cleared only by reset.
- Data registers update only on load; held values are stable while blocked.

Optional Feature:
- Macro ID_EX_WB_BYPASS_EN.
- When defined:
  - On every edge with WbWE=1 and WbRD!=0, each held entry (M, S) whose RS equals WbRD has its Dr1 replaced by WbData. Same rule applies to RT→Dr2.
  - A bundle loaded in that same cycle is compared on its incoming InRS/InRT and loaded with WbData where matching.
  - Register 0 is never bypassed.
- When undefined: the Wb* ports exist but are ignored; operands are held exactly as captured.

Test Plan:
- Reset then continuous InValid=1, OutReady=1, bundles Dr1=0x1,0x2,0x3 → OutValid high from the cycle after the first accept; Out Dr1 sequence 0x1,0x2,0x3 with no gaps; Occupancy=1; InReady=1 throughout.
- Hold OutReady=0 and push 0xA then 0xB:
  - Occupancy=2 and InReady=0; OutDr1 stays 0xA.
  - StallCnt increments each cycle.
  - Release OutReady → 0xA then 0xB, then Occupancy=0.
- With 2 entries held, assert Flush together with OutReady=1 → next cycle OutValid=0, Occupancy=0, InReady=1; StallCnt unchanged.
- Assert RST_N=0 asynchronously mid-stream with Occupancy=2 → immediately OutValid=0, InReady=1, Occupancy=0, StallCnt=0.
- With ID_EX_WB_BYPASS_EN:
  - Hold an entry with RS=5, Dr1=0x10; drive WbWE=1, WbRD=5, WbData=0xDEAD → OutDr1=0xDEAD next cycle.
  - Repeat with WbRD=0 → OutDr1 unchanged.
  - Without the macro → OutDr1 stays 0x10.
